// File: rtl/mem_load_sequencer_if.sv
// Byte-source handshake and shared-bus lane of the program loader.
// master: the loader (drives the bus lane, accepts bytes).
// slave:  the surroundings (byte source, MAR/RAM bus consumers).
interface mem_load_sequencer_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] byte_data;
    logic                  byte_ready;
    logic                  bus_oe;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  mar_load;
    logic                  ram_load;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, bus_oe, bus_out, mar_load, ram_load
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, bus_oe, bus_out, mar_load, ram_load
    );
endinterface

// File: rtl/mem_load_sequencer.sv
// Program loader: halts the CPU at an instruction boundary, takes the bus and
// writes a byte stream into RAM (address into MAR, then data into RAM), then
// clears the PC and releases the bus. All outputs decode from registered state.
module mem_load_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    input  logic                  abort_i,
    input  logic                  cpu_at_fetch_i,
    mem_load_sequencer_if.master  bus,
    output logic                  cpu_hold_o,
    output logic                  pc_clear_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_HOLD       = 3'd1;
    localparam logic [2:0] S_WAIT_BYTE  = 3'd2;
    localparam logic [2:0] S_DRIVE_ADDR = 3'd3;
    localparam logic [2:0] S_DRIVE_DATA = 3'd4;
    localparam logic [2:0] S_FINISH     = 3'd5;
    localparam logic [2:0] S_ERROR      = 3'd6;

    localparam int              TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A zero length means a full RAM image; oversize lengths saturate to it.
    function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
        if (len == '0 || len > FULL_LEN) begin
            return FULL_LEN;
        end
        return len;
    endfunction

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        addr_d  = addr_q;
        to_d    = to_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start_i) begin
                    len_d   = clamp_len(length_i);
                    addr_d  = '0;
                    count_d = '0;
                    to_d    = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cpu_at_fetch_i) begin
                    state_d = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (bus.byte_valid) begin
                    data_d  = bus.byte_data;
                    to_d    = '0;
                    state_d = S_DRIVE_ADDR;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (to_d == TO_LIMIT) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DRIVE_ADDR: begin
                state_d = S_DRIVE_DATA;
            end
            S_DRIVE_DATA: begin
                if (count_q == len_q - (ADDR_WIDTH+1)'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    count_d = count_q + (ADDR_WIDTH+1)'(1);
                    state_d = S_WAIT_BYTE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
        end
    end

    // Byte holding register; never reaches the bus outside DRIVE_DATA, so no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.byte_ready = (state_q == S_WAIT_BYTE);
    assign bus.bus_oe     = (state_q == S_DRIVE_ADDR) || (state_q == S_DRIVE_DATA);
    assign bus.mar_load   = (state_q == S_DRIVE_ADDR);
    assign bus.ram_load   = (state_q == S_DRIVE_DATA);
    assign pc_clear_o     = (state_q == S_FINISH);
    assign done_o         = (state_q == S_FINISH);
    assign error_o        = (state_q == S_ERROR);
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign cpu_hold_o     = busy_o;

    // Bus lane data: address in DRIVE_ADDR, latched byte in DRIVE_DATA, else 0.
    always_comb begin
        bus.bus_out = '0;
        if (state_q == S_DRIVE_ADDR) begin
            bus.bus_out = DATA_WIDTH'(addr_q);
        end else if (state_q == S_DRIVE_DATA) begin
            bus.bus_out = data_q;
        end
    end
endmodule

// File: tb/tb_mem_load_sequencer.sv
// Bench for mem_load_sequencer: directed scenarios plus randomized loads,
// checked against a RAM-write log and the per-byte timing rules.
module tb_mem_load_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, cpu_at_fetch;
    logic [4:0] length;
    logic       cpu_hold, pc_clear, busy, done, error;

    int tests = 0;
    int fails = 0;

    mem_load_sequencer_if #(.DATA_WIDTH(8)) bif ();

    mem_load_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .length_i       (length),
        .abort_i        (abort),
        .cpu_at_fetch_i (cpu_at_fetch),
        .bus            (bif),
        .cpu_hold_o     (cpu_hold),
        .pc_clear_o     (pc_clear),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    // Bus observer: a MAR and a RAM as the datapath would see them.
    logic [3:0]  mar_sh = 4'd0;
    logic [11:0] wlog[$];
    int pcc = 0, donec = 0, oe_bad = 0, addr_bad = 0;
    always @(posedge clk) begin
        if (bif.mar_load) mar_sh <= bif.bus_out[3:0];
        if (bif.mar_load && bif.bus_out > 8'd15) addr_bad <= addr_bad + 1;
        if (bif.ram_load) wlog.push_back({mar_sh, bif.bus_out});
        if (bif.bus_oe !== (bif.mar_load | bif.ram_load)) oe_bad <= oe_bad + 1;
        if (pc_clear) pcc <= pcc + 1;
        if (done) donec <= donec + 1;
    end

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    int stall_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {cpu_hold, pc_clear, busy, done, error, bif.bus_oe, bif.mar_load,
                    bif.ram_load, bif.byte_ready, bif.bus_out}, 32'd0);
    endtask

    // Byte source for the coming edge; counts WAIT_BYTE cycles with no byte.
    task automatic drive_src(input int stall_pct, inout int stalls);
        if (src_q.size() > 0 && (stall_run >= 3 || $urandom_range(99) >= stall_pct)) begin
            bif.byte_valid = 1'b1;
            bif.byte_data  = src_q[0];
        end else begin
            bif.byte_valid = 1'b0;
            bif.byte_data  = 8'($urandom);
        end
        if (bif.byte_ready) begin
            if (bif.byte_valid) begin
                void'(src_q.pop_front());
                stall_run = 0;
            end else begin
                stalls++;
                stall_run++;
            end
        end
    endtask

    // One complete load; exp_q preloaded by caller or filled randomly here.
    task automatic do_load(input string tag, input logic [4:0] len_in, input int fdelay,
                           input int stall_pct);
        int eff, cyc, stalls, pc0, dn0, wl0, bad, holdbad;
        eff = (len_in == 0 || len_in > 16) ? 16 : int'(len_in);
        if (exp_q.size() == 0)
            for (int i = 0; i < eff; i++) exp_q.push_back(8'($urandom));
        src_q = exp_q;
        pc0 = pcc; dn0 = donec; wl0 = wlog.size();
        start = 1'b1; length = len_in; cpu_at_fetch = (fdelay == 0);
        bif.byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, " err clr"}, error, 1'b0);
        cyc = 0; stalls = 0; holdbad = 0; stall_run = 0;
        while (busy === 1'b1 && cyc < 400) begin
            if (cpu_hold !== 1'b1) holdbad++;
            if (fdelay > 0 && cyc < fdelay)
                check({tag, " hold wait"}, {cpu_hold, bif.byte_ready}, 2'b10);
            if (fdelay > 0 && cyc == fdelay + 1)
                check({tag, " wait entry"}, bif.byte_ready, 1'b1);
            cpu_at_fetch = (cyc >= fdelay);
            drive_src(stall_pct, stalls);
            cyc++;
            @(negedge clk);
        end
        bif.byte_valid = 1'b0;
        check({tag, " finished in budget"}, busy, 1'b0);
        check({tag, " cycles"}, cyc, 2 + 3 * eff + fdelay + stalls);
        check({tag, " hold while busy"}, holdbad, 0);
        check({tag, " hold released"}, cpu_hold, 1'b0);
        check({tag, " writes"}, wlog.size() - wl0, eff);
        bad = 0;
        for (int i = 0; i < eff && wl0 + i < wlog.size(); i++)
            if (wlog[wl0 + i] !== {4'(i), exp_q[i]}) bad++;
        check({tag, " ram image"}, bad, 0);
        check({tag, " pc_clear pulses"}, pcc - pc0, 1);
        check({tag, " done pulses"}, donec - dn0, 1);
        exp_q.delete();
    endtask

    initial begin
        int stalls, wl0, pc0, dn0, guard;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cpu_at_fetch = 1'b0; length = '0;
        bif.byte_valid = 1'b0; bif.byte_data = '0;
        repeat (3) @(negedge clk);
        check_zero("reset outputs");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle outputs");

        // Basic three-byte load
        exp_q = '{8'h1E, 8'h2F, 8'hE0};
        do_load("basic", 5'd3, 0, 0);

        // Full image via length 0, bytes 0x00..0x0F
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        do_load("wrap", 5'd0, 0, 0);

        // CPU not at fetch for 4 cycles
        do_load("boundary", 5'd2, 4, 0);

        // Randomized loads: lengths incl. clamping, fetch delays, source stalls
        for (int k = 0; k < 6; k++)
            do_load("random", 5'($urandom_range(0, 20)), $urandom_range(0, 3), 35);

        // Stalled source: one byte of two, then silence
        exp_q = '{8'hA5};
        src_q = exp_q;
        wl0 = wlog.size();
        start = 1'b1; length = 5'd2; cpu_at_fetch = 1'b1;
        @(negedge clk);
        start = 1'b0; stalls = 0; stall_run = 0; guard = 0;
        while (error !== 1'b1 && guard < 100) begin
            drive_src(0, stalls);
            guard++;
            @(negedge clk);
        end
        check("stall error", error, 1'b1);
        check("stall cycles", stalls, 8);
        check("stall hold off", {cpu_hold, busy}, 2'b00);
        check("stall writes", wlog.size() - wl0, 1);
        if (wlog.size() > wl0) check("stall write", wlog[wl0], {4'd0, 8'hA5});
        @(negedge clk);
        check("error sticky", error, 1'b1);
        exp_q.delete();
        do_load("restart", 5'd3, 0, 0);

        // Abort in DRIVE_ADDR of the second byte
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
        src_q = exp_q;
        wl0 = wlog.size(); pc0 = pcc; dn0 = donec;
        start = 1'b1; length = 5'd4; cpu_at_fetch = 1'b1;
        @(negedge clk);
        start = 1'b0; stalls = 0; guard = 0;
        while (!(bif.mar_load === 1'b1 && wlog.size() - wl0 == 1) && guard < 50) begin
            drive_src(0, stalls);
            guard++;
            @(negedge clk);
        end
        check("abort reached addr2", {bif.mar_load, bif.bus_out}, {1'b1, 8'h01});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; bif.byte_valid = 1'b0;
        check("abort idle", {busy, cpu_hold, bif.ram_load}, 3'b000);
        repeat (3) @(negedge clk);
        check("abort writes", wlog.size() - wl0, 1);
        check("abort no pc/done", {pcc - pc0, donec - dn0}, 64'd0);
        src_q.delete(); exp_q.delete();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start+abort", busy, 1'b0);
        @(negedge clk);
        check("start+abort later", {busy, cpu_hold}, 2'b00);

        // Reset during DRIVE_DATA
        for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
        src_q = exp_q;
        start = 1'b1; length = 5'd5; cpu_at_fetch = 1'b1;
        @(negedge clk);
        start = 1'b0; guard = 0;
        while (bif.ram_load !== 1'b1 && guard < 50) begin
            drive_src(0, stalls);
            guard++;
            @(negedge clk);
        end
        check("reached drive_data", bif.ram_load, 1'b1);
        rst = 1'b1; bif.byte_valid = 1'b0;
        @(negedge clk);
        check_zero("mid-load reset");
        rst = 1'b0;
        src_q.delete(); exp_q.delete();
        @(negedge clk);
        do_load("after reset", 5'd7, 1, 20);

        check("bus_oe only with strobes", oe_bad, 0);
        check("mar address range", addr_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
